// File: rtl/spi_slave_serial_if.sv
// spi_slave_serial_if: serial pins, mode pins and parallel word handshake of the SPI slave
//   CKP, CPH           : SPI clock polarity / phase (static while selected)
//   SCK, CS, MOSI      : serial clock, active-low select and data from the master
//   MISO, MISO_OE      : serial data to the master and its drive enable
//   tx_data, tx_load   : word to send and its write strobe into the holding register
//   tx_ready           : holding register empty
//   rx_data, rx_valid  : last complete received word and its one-cycle strobe
//   frame_err, busy    : select released mid-frame pulse, slave not idle
interface spi_slave_serial_if #(parameter int WIDTH = 16);
   logic             CKP;
   logic             CPH;
   logic             SCK;
   logic             CS;
   logic             MOSI;
   logic             MISO;
   logic             MISO_OE;
   logic [WIDTH-1:0] tx_data;
   logic             tx_load;
   logic             tx_ready;
   logic [WIDTH-1:0] rx_data;
   logic             rx_valid;
   logic             frame_err;
   logic             busy;
   modport slave (
      input  CKP, CPH, SCK, CS, MOSI, tx_data, tx_load,
      output MISO, MISO_OE, tx_ready, rx_data, rx_valid, frame_err, busy
   );
   modport master (
      output CKP, CPH, SCK, CS, MOSI, tx_data, tx_load,
      input  MISO, MISO_OE, tx_ready, rx_data, rx_valid, frame_err, busy
   );
endinterface

// File: rtl/spi_slave_serial.sv
// spi_slave_serial: oversampled SPI slave (all four modes) with tx holding register and rx word output
//   CLK   : system clock, SCK at most CLK/8
//   RESET : asynchronous, active-low
//   bus   : spi_slave_serial_if slave modport (serial pins, mode pins, tx/rx word handshake)
module spi_slave_serial #(
   parameter int WIDTH = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   spi_slave_serial_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam int CW = $clog2(WIDTH + 1);
   state_t           state_q, state_d;
   logic [2:0]       sck_q;
   logic [2:0]       cs_q;
   logic [1:0]       mosi_q;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
   logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic [WIDTH-1:0] rx_data_q, rx_data_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             tx_ready_q, tx_ready_d;
   logic             rx_valid_q, rx_valid_d;
   logic             frame_err_q, frame_err_d;
   logic             lead, trail, smp, drv, cs_s, cs_fall, load;
   // SCK is synchronized after XOR with CKP, so the leading edge is always a
   // rising edge of sck_q and a reset value of 0 stands for the idle level
   assign lead    = sck_q[1] & ~sck_q[2];
   assign trail   = ~sck_q[1] & sck_q[2];
   assign smp     = bus.CPH ? trail : lead;
   assign drv     = bus.CPH ? lead : trail;
   assign cs_s    = cs_q[1];
   assign cs_fall = ~cs_q[1] & cs_q[2];
   assign bus.MISO_OE   = ~cs_s;
   assign bus.MISO      = ~cs_s & tx_sh_q[WIDTH-1];
   assign bus.tx_ready  = tx_ready_q;
   assign bus.rx_data   = rx_data_q;
   assign bus.rx_valid  = rx_valid_q;
   assign bus.frame_err = frame_err_q;
   assign bus.busy      = state_q != IDLE;
   always_ff @(posedge CLK or negedge RESET)
      if (!RESET) begin
         sck_q       <= '0;
         cs_q        <= '1;
         mosi_q      <= '0;
         state_q     <= IDLE;
         hold_q      <= '0;
         tx_sh_q     <= '0;
         rx_sh_q     <= '0;
         rx_data_q   <= '0;
         cnt_q       <= '0;
         tx_ready_q  <= 1'b1;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sck_q       <= {sck_q[1:0], bus.SCK ^ bus.CKP};
         cs_q        <= {cs_q[1:0], bus.CS};
         mosi_q      <= {mosi_q[0], bus.MOSI};
         state_q     <= state_d;
         hold_q      <= hold_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         rx_data_q   <= rx_data_d;
         cnt_q       <= cnt_d;
         tx_ready_q  <= tx_ready_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      tx_sh_d     = tx_sh_q;
      rx_sh_d     = rx_sh_q;
      rx_data_d   = rx_data_q;
      cnt_d       = cnt_q;
      tx_ready_d  = tx_ready_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      load        = 1'b0;
      if (bus.tx_load) begin
         hold_d     = bus.tx_data;
         tx_ready_d = 1'b0;
      end
      case (state_q)
         IDLE:
            if (cs_fall) begin
               state_d = SHIFT;
               load    = 1'b1;
            end
         SHIFT:
            if (cs_s) begin
               state_d     = IDLE;
               frame_err_d = cnt_q != '0;
               cnt_d       = '0;
            end else begin
               if (smp) begin
                  rx_sh_d = {rx_sh_q[WIDTH-2:0], mosi_q[1]};
                  cnt_d   = cnt_q + CW'(1);
                  if (cnt_q == CW'(WIDTH - 1))
                     state_d = DONE;
               end
               // A drive edge before the first sample of a frame never shifts:
               // it is the CPH=1 first leading edge, or the trailing edge that
               // closes the previous frame of a back-to-back CPH=0 transfer
               if (drv && cnt_q != '0)
                  tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
            end
         DONE: begin
            rx_data_d  = rx_sh_q;
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            state_d    = cs_s ? IDLE : SHIFT;
            load       = ~cs_s;
         end
         default: state_d = IDLE;
      endcase
      // Frame load takes a coincident tx_load word directly and leaves the
      // holding register marked empty; an empty holding register sends zeros
      if (load) begin
         tx_sh_d    = bus.tx_load ? bus.tx_data : (tx_ready_q ? '0 : hold_q);
         tx_ready_d = 1'b1;
         cnt_d      = '0;
      end
   end
endmodule

// File: tb/tb_spi_slave_serial.sv
// tb_spi_slave_serial: directed table-driven bench for spi_slave_serial acting as SPI master
module tb_spi_slave_serial;
   localparam int H = 8;
   typedef struct {
      logic        ckp;
      logic        cph;
      logic        ld;
      logic [15:0] tx;
      logic [15:0] mosi;
      logic [15:0] miso;
      logic [15:0] rx;
   } vec_t;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   int   rxv_n;
   int   ferr_n;
   spi_slave_serial_if #(.WIDTH(16)) bus();
   spi_slave_serial #(.WIDTH(16)) dut (
      .CLK(clk),
      .RESET(rst_n),
      .bus(bus)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   initial begin
      rxv_n  = 0;
      ferr_n = 0;
   end
   always @(negedge clk) begin
      if (bus.rx_valid === 1'b1)
         rxv_n <= rxv_n + 1;
      if (bus.frame_err === 1'b1)
         ferr_n <= ferr_n + 1;
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic pulse_load(input logic [15:0] w);
      bus.tx_data = w;
      bus.tx_load = 1'b1;
      @(negedge clk);
      bus.tx_load = 1'b0;
   endtask
   task automatic set_mode(input logic ckp, input logic cph);
      bus.CKP = ckp;
      bus.CPH = cph;
      bus.SCK = ckp;
      repeat (4) @(negedge clk);
   endtask
   task automatic cs_low(input logic co, input logic [15:0] cow);
      @(negedge clk);
      bus.CS = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (co) begin
         bus.tx_data = cow;
         bus.tx_load = 1'b1;
      end
      @(negedge clk);
      bus.tx_load = 1'b0;
      repeat (H) @(negedge clk);
      chk("miso_oe_sel", bus.MISO_OE, 1);
      chk("busy_sel", bus.busy, 1);
   endtask
   task automatic cs_high();
      repeat (H) @(negedge clk);
      bus.CS = 1'b1;
      repeat (12) @(negedge clk);
   endtask
   task automatic shift_bits(input logic [31:0] m, input int n, output logic [31:0] got);
      got = '0;
      for (int i = n - 1; i >= 0; i--) begin
         if (!bus.CPH) begin
            bus.MOSI = m[i];
            repeat (H) @(negedge clk);
            bus.SCK = ~bus.CKP;
            got = {got[30:0], bus.MISO};
            repeat (H) @(negedge clk);
            bus.SCK = bus.CKP;
         end else begin
            bus.SCK = ~bus.CKP;
            bus.MOSI = m[i];
            repeat (H) @(negedge clk);
            bus.SCK = bus.CKP;
            got = {got[30:0], bus.MISO};
            repeat (H) @(negedge clk);
         end
      end
   endtask
   vec_t        v[6];
   logic [31:0] got;
   int          r0, f0;
   initial begin
      v[0] = '{1'b0, 1'b0, 1'b1, 16'hA55A, 16'h1234, 16'hA55A, 16'h1234};
      v[1] = '{1'b0, 1'b1, 1'b1, 16'hC3C3, 16'hBEEF, 16'hC3C3, 16'hBEEF};
      v[2] = '{1'b1, 1'b0, 1'b1, 16'hC3C3, 16'hBEEF, 16'hC3C3, 16'hBEEF};
      v[3] = '{1'b1, 1'b1, 1'b1, 16'hC3C3, 16'hBEEF, 16'hC3C3, 16'hBEEF};
      v[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
      v[5] = '{1'b1, 1'b1, 1'b1, 16'h9696, 16'h1234, 16'h9696, 16'h1234};
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.CKP = 1'b0;
      bus.CPH = 1'b0;
      bus.SCK = 1'b0;
      bus.CS = 1'b1;
      bus.MOSI = 1'b0;
      bus.tx_data = '0;
      bus.tx_load = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_miso", bus.MISO, 0);
      chk("rst_miso_oe", bus.MISO_OE, 0);
      chk("rst_rx_data", bus.rx_data, 0);
      chk("rst_rx_valid", bus.rx_valid, 0);
      chk("rst_frame_err", bus.frame_err, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_tx_ready", bus.tx_ready, 1);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_busy", bus.busy, 0);
      for (int i = 0; i < 6; i++) begin
         set_mode(v[i].ckp, v[i].cph);
         r0 = rxv_n;
         f0 = ferr_n;
         if (v[i].ld) begin
            pulse_load(~v[i].tx);
            chk("tx_ready_clr", bus.tx_ready, 0);
            pulse_load(v[i].tx);
         end
         cs_low(1'b0, 16'h0);
         shift_bits({16'h0, v[i].mosi}, 16, got);
         cs_high();
         chk($sformatf("v%0d_rx_data", i), bus.rx_data, v[i].rx);
         chk($sformatf("v%0d_miso", i), got[15:0], v[i].miso);
         chk($sformatf("v%0d_rx_valid_n", i), rxv_n - r0, 1);
         chk($sformatf("v%0d_frame_err_n", i), ferr_n - f0, 0);
         chk($sformatf("v%0d_tx_ready", i), bus.tx_ready, 1);
         chk($sformatf("v%0d_busy", i), bus.busy, 0);
      end
      set_mode(1'b0, 1'b0);
      r0 = rxv_n;
      f0 = ferr_n;
      cs_low(1'b0, 16'h0);
      shift_bits(32'h00FF, 7, got);
      cs_high();
      chk("abort_frame_err_n", ferr_n - f0, 1);
      chk("abort_rx_valid_n", rxv_n - r0, 0);
      chk("abort_rx_data", bus.rx_data, 16'h1234);
      chk("abort_busy", bus.busy, 0);
      r0 = rxv_n;
      f0 = ferr_n;
      pulse_load(16'h0001);
      cs_low(1'b0, 16'h0);
      fork
         shift_bits(32'hCAFEF00D, 32, got);
         begin
            repeat (40) @(negedge clk);
            pulse_load(16'h0002);
         end
      join
      cs_high();
      chk("b2b_miso", got, 32'h00010002);
      chk("b2b_rx_data", bus.rx_data, 16'hF00D);
      chk("b2b_rx_valid_n", rxv_n - r0, 2);
      chk("b2b_frame_err_n", ferr_n - f0, 0);
      pulse_load(16'h1111);
      cs_low(1'b1, 16'h3C3C);
      shift_bits(32'h0F0F, 16, got);
      cs_high();
      chk("coload_miso", got[15:0], 16'h3C3C);
      chk("coload_tx_ready", bus.tx_ready, 1);
      chk("coload_rx_data", bus.rx_data, 16'h0F0F);
      r0 = rxv_n;
      f0 = ferr_n;
      cs_low(1'b0, 16'h0);
      shift_bits(32'h1F, 5, got);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_rx_data", bus.rx_data, 0);
      chk("mid_rst_miso_oe", bus.MISO_OE, 0);
      bus.CS = 1'b1;
      bus.SCK = bus.CKP;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      cs_low(1'b0, 16'h0);
      shift_bits(32'h5A5A, 16, got);
      cs_high();
      chk("post_rst_rx_data", bus.rx_data, 16'h5A5A);
      chk("post_rst_rx_valid_n", rxv_n - r0, 1);
      chk("post_rst_frame_err_n", ferr_n - f0, 0);
      chk("post_rst_miso", got[15:0], 16'h0000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spi_slave_serial.md
SPI_SLAVE_SERIAL -- requirements
Module: spi_slave_serial

Interface
REQ-001 Parameter: WIDTH, 16, frame length in bits; legal range 8..32.
REQ-002 CLK  input  1  system clock; all state changes on posedge CLK; SCK frequency SHALL be at most CLK/8.
REQ-003 RESET  input  1  reset, asynchronous, active-low.
REQ-004 CKP  input  1  SPI clock polarity (idle level of SCK); held static while CS=0.
REQ-005 CPH  input  1  SPI clock phase; held static while CS=0.
REQ-006 SCK  input  1  serial clock from master, asynchronous to CLK.
REQ-007 CS  input  1  chip select from master, active-low, asynchronous.
REQ-008 MOSI  input  1  serial data from master, MSB first.
REQ-009 MISO  output  1  serial data to master, MSB first.
REQ-010 MISO_OE  output  1  MISO drive enable, 1 while selected.
REQ-011 tx_data  input  WIDTH  word to transmit.
REQ-012 tx_load  input  1  write tx_data into holding register.
REQ-013 tx_ready  output  1  holding register empty.
REQ-014 rx_data  output  WIDTH  last complete received word.
REQ-015 rx_valid  output  1  one-cycle pulse, rx_data updated.
REQ-016 frame_err  output  1  one-cycle pulse, CS released mid-frame.
REQ-017 busy  output  1  1 when state is not IDLE.

Function
REQ-018 SCK, CS, MOSI SHALL each pass a 2-flop synchronizer; SCK edges SHALL be detected from synchronized SCK versus a third delay flop.
REQ-019 Leading edge = rising if CKP=0, falling if CKP=1; trailing edge = the opposite.
REQ-020 Sample edge = leading if CPH=0, trailing if CPH=1; drive edge = the other.
REQ-021 FSM states: IDLE, SHIFT, DONE.
REQ-022 IDLE->SHIFT on synchronized CS falling; on this transition copy holding register to tx shift register, set tx_ready=1, clear bit counter.
REQ-023 If holding register empty at frame load, tx shift register SHALL load all-zeros.
REQ-024 In SHIFT, each sample edge SHALL shift synchronized MOSI into rx shift register LSB and increment bit counter.
REQ-025 MISO SHALL equal tx shift register MSB; the register SHALL shift left on each drive edge, except the first drive edge of a frame when CPH=1.
REQ-026 SHIFT->DONE on the sample edge that makes bit counter reach WIDTH.
REQ-027 DONE (one cycle): rx_data <= rx shift register, rx_valid=1, bit counter cleared.
REQ-028 DONE->SHIFT if synchronized CS still 0, reloading tx shift register from holding register (back-to-back frames); else DONE->IDLE.
REQ-029 SHIFT->IDLE when synchronized CS rises with bit counter nonzero: frame_err=1 for one cycle, rx_data unchanged, no rx_valid.
REQ-030 CS rise with bit counter zero in SHIFT: return to IDLE, no frame_err.
REQ-031 tx_load SHALL write holding register and clear tx_ready next cycle; tx_load while tx_ready=0 SHALL overwrite.
REQ-032 tx_load coincident with a frame load SHALL load tx_data directly into tx shift register and leave tx_ready=1.
REQ-033 MISO_OE = inverse of synchronized CS; MISO SHALL be 0 when MISO_OE=0.
REQ-034 CKP/CPH changes while CS=0: behaviour undefined, not checked.

Reset
REQ-035 On RESET=0: state IDLE, MISO=0, MISO_OE=0, rx_data=0, rx_valid=0, frame_err=0, busy=0, tx_ready=1, all shift registers, counters, synchronizers (SCK stages to CKP, CS stages to 1) cleared.
REQ-036 RESET asserted mid-frame SHALL abort without frame_err; after release, next CS falling starts a fresh frame.

Verification
REQ-037 Mode 0 (CKP=0,CPH=0): tx_load 16'hA55A, master sends 16'h1234 -> MISO stream 16'hA55A, rx_data=16'h1234, one rx_valid, tx_ready=1.
REQ-038 Modes 1,2,3: master 16'hBEEF, tx 16'hC3C3 -> rx_data=16'hBEEF, MISO stream 16'hC3C3 in each mode.
REQ-039 No tx_load, master sends 16'hFFFF -> MISO all zeros, rx_data=16'hFFFF.
REQ-040 CS held low for 32 SCK cycles, holding reloaded between frames with 16'h0001 then 16'h0002 -> two rx_valid pulses, MISO streams 16'h0001,16'h0002.
REQ-041 CS released after 7 bits -> frame_err pulse, rx_data keeps previous 16'h1234, state IDLE.
REQ-042 RESET asserted after 5 bits, released, full frame 16'h5A5A -> rx_data=16'h5A5A, no frame_err.
